// File: rtl/spi_counter_slave.sv
// SPI mode-0 slave owning the 14-bit display count: 16-bit frames {cmd[1:0], data[13:0]}.
// Define COUNTER_AUTO_INC_EN to add a free-running auto-increment tick every TICK_MAX clocks.
module spi_counter_slave #(
  parameter int MAX_COUNT = 9999,
  parameter int TICK_MAX  = 10_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        cs_n,
  output logic        miso,
  output logic [13:0] counter,
  output logic        counter_valid,
  output logic        frame_err
);

  localparam int CNT_W   = 14;
  localparam int FRAME_W = 16;
  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_COUNT);

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_CLEAR = 2'b10;
  localparam logic [1:0] CMD_INC   = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    DONE    = 2'd2,
    WAIT_CS = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] d);
    return (d > MAX_VAL) ? MAX_VAL : d;
  endfunction

  function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] c);
    return (c >= MAX_VAL) ? '0 : c + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] apply_cmd(input logic [FRAME_W-1:0] frame,
                                                 input logic [CNT_W-1:0]   cur);
    logic [CNT_W-1:0] nxt;
    nxt = cur;
    case (frame[15:14])
      CMD_NOP:   nxt = cur;
      CMD_WRITE: nxt = sat_count(frame[13:0]);
      CMD_CLEAR: nxt = '0;
      CMD_INC:   nxt = wrap_inc(cur);
      default:   nxt = cur;
    endcase
    return nxt;
  endfunction

  state_t state, state_next;

  logic sclk_p0, sclk_p1, sclk_p2;
  logic cs_p0, cs_p1, cs_p2;
  logic mosi_p0, mosi_p1;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [FRAME_W-1:0] tx_shift;
  logic [FRAME_W-1:0] rx_shift;
  logic [4:0]         bit_cnt;
  logic               last_bit;

  logic load, capture, advance, frame_done, frame_abort;
  logic tick;

  // Stage p0/p1: two-flop synchronizers; p2: previous value for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_p0 <= 1'b0;
      sclk_p1 <= 1'b0;
      sclk_p2 <= 1'b0;
      cs_p0   <= 1'b1;
      cs_p1   <= 1'b1;
      cs_p2   <= 1'b1;
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
    end else begin
      sclk_p0 <= sclk;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      cs_p0   <= cs_n;
      cs_p1   <= cs_p0;
      cs_p2   <= cs_p1;
      mosi_p0 <= mosi;
      mosi_p1 <= mosi_p0;
    end
  end

  assign sclk_rise = sclk_p1 & ~sclk_p2;
  assign sclk_fall = ~sclk_p1 & sclk_p2;
  assign cs_rise   = cs_p1 & ~cs_p2;
  assign cs_fall   = ~cs_p1 & cs_p2;
  assign last_bit  = (bit_cnt == 5'd15);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // A 16th sclk rise coinciding with cs_n rise completes the frame rather than aborting it.
  // WAIT_CS leaves on the cs_n level so a rise consumed during DONE is not lost.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cs_fall) state_next = SHIFT;
      SHIFT: begin
        if (sclk_rise && last_bit) state_next = DONE;
        else if (cs_rise)          state_next = IDLE;
      end
      DONE:    state_next = WAIT_CS;
      WAIT_CS: if (cs_p1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    miso        = 1'b0;
    load        = 1'b0;
    capture     = 1'b0;
    advance     = 1'b0;
    frame_done  = 1'b0;
    frame_abort = 1'b0;
    case (state)
      IDLE:  load = cs_fall;
      SHIFT: begin
        miso        = tx_shift[FRAME_W-1];
        capture     = sclk_rise;
        advance     = sclk_fall;
        frame_abort = cs_rise && !(sclk_rise && last_bit);
      end
      DONE:    frame_done = 1'b1;
      default: ;
    endcase
  end

  // Frame shift registers are pure data; only entry via load makes them observable
  always_ff @(posedge clk) begin
    if (load)         tx_shift <= {2'b00, counter};
    else if (advance) tx_shift <= {tx_shift[FRAME_W-2:0], 1'b0};
    if (capture)      rx_shift <= {rx_shift[FRAME_W-2:0], mosi_p1};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       bit_cnt <= '0;
    else if (load)    bit_cnt <= '0;
    else if (capture) bit_cnt <= bit_cnt + 5'd1;
  end

`ifdef COUNTER_AUTO_INC_EN
  localparam int TICK_W = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  logic [TICK_W-1:0] tick_cnt;

  assign tick = (tick_cnt == TICK_W'(TICK_MAX - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TICK_W'(1);
  end
`else
  // No auto-increment source; the comparison is constant false for any legal TICK_MAX.
  assign tick = (TICK_MAX < 0);
`endif

  // Command apply stage: result and strobes become visible the cycle after DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter       <= '0;
      counter_valid <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      counter_valid <= frame_done;
      frame_err     <= frame_abort;
      if (frame_done)  counter <= apply_cmd(rx_shift, counter);
      else if (tick)   counter <= wrap_inc(counter);
    end
  end

endmodule

// File: tb/tb_spi_counter_slave.sv
// Directed bench for spi_counter_slave: mode-0 master at sclk = clk/10 driving hand-computed frames.
module tb_spi_counter_slave;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        cs_n = 1'b1;
  logic        miso;
  logic [13:0] counter;
  logic        counter_valid;
  logic        frame_err;

  int checks = 0;
  int failures = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  logic [13:0] lat_before;
  logic [13:0] lat_after;

  always #5 clk = ~clk;

  spi_counter_slave dut (
    .clk           (clk),
    .reset         (reset),
    .sclk          (sclk),
    .mosi          (mosi),
    .cs_n          (cs_n),
    .miso          (miso),
    .counter       (counter),
    .counter_valid (counter_valid),
    .frame_err     (frame_err)
  );

  always @(negedge clk) begin
    if (counter_valid)              valid_cnt <= valid_cnt + 1;
    if (frame_err)                  err_cnt   <= err_cnt + 1;
    if (counter_valid && frame_err) both_cnt  <= both_cnt + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode 0: data set while sclk low, both sides sample on rise, slave shifts on fall.
  task automatic spi_xfer(input logic [15:0] word, input int nbits, input int extra,
                          input bit cs_last, output logic [15:0] rx);
    rx = '0;
    cs_n = 1'b0;
    wait_neg(4);
    for (int i = 0; i < nbits; i++) begin
      mosi = word[15-i];
      wait_neg(5);
      if (cs_last && i == nbits - 1) cs_n = 1'b1;
      sclk = 1'b1;
      rx[15-i] = miso;
      if (i == 15) begin
        wait_neg(3);
        lat_before = counter;
        wait_neg(1);
        lat_after = counter;
        wait_neg(1);
      end else begin
        wait_neg(5);
      end
      sclk = 1'b0;
    end
    for (int i = 0; i < extra; i++) begin
      wait_neg(5);
      sclk = 1'b1;
      wait_neg(5);
      sclk = 1'b0;
    end
    wait_neg(5);
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_neg(10);
  endtask

  task automatic run_frame(input string tag, input logic [15:0] word, input int nbits,
                           input int extra, input bit cs_last, input logic [15:0] exp_rx,
                           input int exp_cnt, input int exp_valid, input int exp_err);
    int v0, e0;
    logic [15:0] rx;
    v0 = valid_cnt;
    e0 = err_cnt;
    spi_xfer(word, nbits, extra, cs_last, rx);
    check($sformatf("%s.miso_rx", tag), int'(rx), int'(exp_rx));
    check($sformatf("%s.counter", tag), int'(counter), exp_cnt);
    check($sformatf("%s.valid_pulses", tag), valid_cnt - v0, exp_valid);
    check($sformatf("%s.err_pulses", tag), err_cnt - e0, exp_err);
    check($sformatf("%s.miso_idle", tag), int'(miso), 0);
    if (nbits == 16) begin
      check($sformatf("%s.lat_3clk_old", tag), int'(lat_before), int'(exp_rx[13:0]));
      check($sformatf("%s.lat_4clk_new", tag), int'(lat_after), exp_cnt);
    end
  endtask

  initial begin
    int v0, e0;

    wait_neg(3);
    check("reset.counter", int'(counter), 0);
    check("reset.counter_valid", int'(counter_valid), 0);
    check("reset.frame_err", int'(frame_err), 0);
    check("reset.miso", int'(miso), 0);
    reset = 1'b1;
    wait_neg(5);

    run_frame("write_3375",  16'h4D2F, 16, 0, 1'b0, 16'h0000, 3375, 1, 0);
    run_frame("nop_readback", 16'h0000, 16, 0, 1'b0, 16'h0D2F, 3375, 1, 0);
    run_frame("write_clamp", 16'h7FFF, 16, 0, 1'b0, 16'h0D2F, 9999, 1, 0);
    run_frame("inc_wrap",    16'hC000, 16, 0, 1'b0, 16'h270F, 0,    1, 0);
    run_frame("inc_from_0",  16'hC000, 16, 0, 1'b0, 16'h0000, 1,    1, 0);
    run_frame("write_42",    16'h402A, 16, 0, 1'b0, 16'h0001, 42,   1, 0);
    run_frame("abort_9",     16'h8000, 9,  0, 1'b0, 16'h0000, 42,   0, 1);
    run_frame("clear",       16'h8000, 16, 0, 1'b0, 16'h002A, 0,    1, 0);
    run_frame("extra_sclk",  16'h4064, 16, 8, 1'b0, 16'h0000, 100,  1, 0);
    run_frame("write_max",   16'h670F, 16, 0, 1'b0, 16'h0064, 9999, 1, 0);
    run_frame("cs_with_16th", 16'h4007, 16, 0, 1'b1, 16'h270F, 7,   1, 0);
    run_frame("nop_after_cs", 16'h0000, 16, 0, 1'b0, 16'h0007, 7,   1, 0);

    // Reset in the middle of a WRITE frame
    v0 = valid_cnt;
    e0 = err_cnt;
    cs_n = 1'b0;
    wait_neg(4);
    for (int i = 0; i < 8; i++) begin
      mosi = (i == 1);
      wait_neg(5);
      sclk = 1'b1;
      wait_neg(5);
      sclk = 1'b0;
    end
    reset = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_neg(2);
    check("midreset.counter", int'(counter), 0);
    check("midreset.miso", int'(miso), 0);
    reset = 1'b1;
    wait_neg(20);
    check("midreset.counter_after", int'(counter), 0);
    check("midreset.valid_pulses", valid_cnt - v0, 0);
    check("midreset.err_pulses", err_cnt - e0, 0);

    run_frame("post_reset_write", 16'h4D2F, 16, 0, 1'b0, 16'h0000, 3375, 1, 0);

    check("valid_err_overlap", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_counter_slave.md
Name: spi_counter_slave

Overview:
- SPI slave (mode 0, MSB first, 16-bit frames) that owns the 14-bit display count.
- Drives `counter[13:0]` directly into the 4-digit FND controller.
- An external master can write, clear or increment the count, and reads back the current value on MISO in the same frame.
- All SPI inputs are asynchronous to `clk` and are oversampled.

Parameters:
- MAX_COUNT, 9999, highest legal count value; writes above it clamp to it, increments wrap to 0 after it.
- TICK_MAX, 10_000_000, `clk` cycles per auto-increment tick (used only with COUNTER_AUTO_INC_EN).

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- sclk  input  1  SPI clock from master, async; frequency ≤ clk/8.
- mosi  input  1  SPI data in, async.
- cs_n  input  1  SPI chip select, active-low, async.
- miso  output  1  SPI data out; 0 when not selected.
- counter  output  14  current count, always ≤ MAX_COUNT.
- counter_valid  output  1  1-cycle pulse when a frame command has been applied.
- frame_err  output  1  1-cycle pulse when a frame aborts early.

Behaviour:
- Reset (reset=0, async): counter=0, counter_valid=0, frame_err=0, miso=0, state=IDLE, all synchronizers cleared (sclk/mosi to 0, cs_n to 1).
- Input synchronization:
  - sclk, mosi and cs_n each pass through a 2-FF synchronizer.
  - A third register on sclk and cs_n gives edge detect (rise = synced 1 and previous 0; fall = the opposite).
- Frame format: bit[15:14]=cmd, bit[13:0]=data.
  - cmd 00: NOP.
  - cmd 01: WRITE, counter = min(data, MAX_COUNT).
  - cmd 10: CLEAR, counter = 0.
  - cmd 11: INC, counter = (counter==MAX_COUNT) ? 0 : counter+1.
- FSM states: IDLE, SHIFT, DONE, WAIT_CS.
  - IDLE: on cs_n fall, load tx_shift={2'b00,counter}, bit_cnt=0, miso=tx_shift[15], go to SHIFT.
  - SHIFT, sclk rise: rx_shift={rx_shift[14:0],mosi_sync}, bit_cnt+1. On the rise that makes 16 bits, go to DONE.
  - SHIFT, sclk fall: tx_shift<<1, miso=new tx_shift[15].
  - SHIFT, cs_n rise before 16 bits: frame_err=1 for one cycle, counter unchanged, go to IDLE.
  - DONE (exactly 1 cycle): decode rx_shift and apply the command. counter and counter_valid=1 are registered at the end of this cycle, so they are visible in the following cycle. Then go to WAIT_CS. NOP also pulses counter_valid.
  - WAIT_CS: ignore all sclk edges; on cs_n rise go to IDLE with no error. miso=0.
- Latency: counter updates 4 clk cycles after the raw 16th sclk rising edge (2 sync + edge detect + DONE).
- MISO read-back: the snapshot is taken at cs_n fall. Bits [15:14] are 0 and bits [13:0] are the pre-frame counter.
- miso is 0 whenever the state is IDLE or WAIT_CS.
- Simultaneous cs_n rise and 16th sclk rise in the same synced cycle: the frame completes (DONE), no frame_err.
- Reset mid-frame: the frame is discarded, counter returns to 0, no pulses are generated.
- counter_valid and frame_err are never high in the same cycle.

Optional Feature:
- Macro: COUNTER_AUTO_INC_EN.
- Defined:
  - A free-running tick counter (width $clog2(TICK_MAX)) pulses every TICK_MAX clk cycles.
  - Each tick increments counter with wrap at MAX_COUNT. counter_valid is not pulsed by ticks.
  - If a tick and DONE fall in the same cycle, the SPI command wins and the tick is dropped.
  - The tick counter resets to 0 on reset.
- Not defined: no tick logic is generated; counter changes only via SPI commands.

Test Plan:
- Reset then WRITE frame 16'h4D2F (cmd 01, data 0x0D2F=3375) at sclk=clk/10 -> counter=3375, counter_valid one 1-cycle pulse, frame_err stays 0.
- With counter=3375, send NOP 16'h0000 -> miso bits read 16'h0D2F MSB first, counter unchanged, counter_valid pulses once.
- WRITE 16'h7FFF (data 16383) -> counter clamps to 9999. Then INC 16'hC000 -> counter=0. Then INC again -> counter=1.
- counter=42, deassert cs_n after 9 sclk edges -> frame_err 1-cycle pulse, counter stays 42. The next full CLEAR 16'h8000 -> counter=0.
- Send WRITE 16'h4064 (data 100) followed by 8 extra sclk pulses before cs_n rise -> counter=100, exactly one counter_valid pulse, no frame_err.
- With COUNTER_AUTO_INC_EN and TICK_MAX=10, counter=9998 -> after 10 cycles 9999, after 20 cycles 0. Force DONE of WRITE 5 on the same cycle as a tick -> counter=5.
